// File: rtl/tcdm_stall_injector_if.sv
// ============================================================================
// hwpe_stream_intf_tcdm : TCDM request/response channel bundle
// Revision: 1.0
// ============================================================================
`default_nettype none

interface hwpe_stream_intf_tcdm;
   logic        req;
   logic        gnt;
   logic [31:0] add;
   logic        wen;
   logic [3:0]  be;
   logic [31:0] data;
   logic [31:0] r_data;
   logic        r_valid;

   modport master (
      output req, add, wen, be, data,
      input  gnt, r_data, r_valid
   );

   modport slave (
      input  req, add, wen, be, data,
      output gnt, r_data, r_valid
   );
endinterface

`default_nettype wire

// File: rtl/tcdm_stall_injector.sv
// ============================================================================
// tcdm_stall_injector : LFSR-driven grant-stall injector between an
// accelerator and a TCDM memory model. Optional macro TCDM_STALL_RESP_DELAY_EN
// adds one registered response stage per port.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tcdm_stall_injector #(
   parameter int unsigned MP         = 1,
   parameter int unsigned STALL_PROB = 64,
   parameter int unsigned MAX_STALL  = 4,
   parameter logic [7:0]  LFSR_SEED  = 8'h5A
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 enable_i,
   input  logic                 clear_i,
   hwpe_stream_intf_tcdm.slave  tcdm_slv [MP],
   hwpe_stream_intf_tcdm.master tcdm_mst [MP],
   output logic [MP-1:0][31:0]  stall_cnt_o
);

   localparam logic [7:0] C_THRESH  = 8'(STALL_PROB);
   localparam logic [3:0] C_MAX_RUN = 4'(MAX_STALL);
   // Right-shifting Galois form of x^8+x^6+x^5+x^4+1
   localparam logic [7:0] C_TAPS    = 8'hB8;

   for (genvar i = 0; i < MP; i++) begin : g_port
      localparam logic [7:0] C_SEED_RAW = LFSR_SEED ^ 8'(i);
      localparam logic [7:0] C_SEED     = (C_SEED_RAW == 8'h00) ? 8'hA5 : C_SEED_RAW;

      logic [7:0]  lfsr_q, lfsr_d;
      logic [3:0]  run_q, run_d;
      logic [31:0] cnt_q, cnt_d;
      logic        req, gnt, stall;

      // Stall decision depends only on flops and the incoming request, never on mst.gnt
      assign req   = tcdm_slv[i].req;
      assign stall = enable_i & req & (lfsr_q < C_THRESH) & (run_q < C_MAX_RUN);
      assign gnt   = rst_ni & tcdm_mst[i].gnt & ~stall;

      assign tcdm_mst[i].req  = rst_ni & req & ~stall;
      assign tcdm_mst[i].add  = tcdm_slv[i].add;
      assign tcdm_mst[i].wen  = tcdm_slv[i].wen;
      assign tcdm_mst[i].be   = tcdm_slv[i].be;
      assign tcdm_mst[i].data = tcdm_slv[i].data;
      assign tcdm_slv[i].gnt  = gnt;

      always_comb begin
         lfsr_d = lfsr_q;
         if (enable_i) begin
            lfsr_d = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? C_TAPS : 8'h00);
         end

         run_d = run_q;
         if (stall) begin
            run_d = run_q + 4'd1;
         end else if (!req || gnt) begin
            run_d = 4'd0;
         end

         cnt_d = cnt_q;
         if (clear_i) begin
            cnt_d = 32'd0;
         end else if (stall && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_d = cnt_q + 32'd1;
         end
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            lfsr_q <= C_SEED;
            run_q  <= 4'd0;
            cnt_q  <= 32'd0;
         end else begin
            lfsr_q <= lfsr_d;
            run_q  <= run_d;
            cnt_q  <= cnt_d;
         end
      end

      assign stall_cnt_o[i] = cnt_q;

`ifdef TCDM_STALL_RESP_DELAY_EN
      logic [31:0] r_data_q, r_data_d;
      logic        r_valid_q, r_valid_d;

      always_comb begin
         r_data_d  = tcdm_mst[i].r_data;
         r_valid_d = tcdm_mst[i].r_valid;
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            r_data_q  <= 32'd0;
            r_valid_q <= 1'b0;
         end else begin
            r_data_q  <= r_data_d;
            r_valid_q <= r_valid_d;
         end
      end

      assign tcdm_slv[i].r_data  = r_data_q;
      assign tcdm_slv[i].r_valid = r_valid_q;
`else
      assign tcdm_slv[i].r_data  = tcdm_mst[i].r_data;
      assign tcdm_slv[i].r_valid = tcdm_mst[i].r_valid;
`endif
   end

endmodule

`default_nettype wire

// File: tb/tb_tcdm_stall_injector.sv
// ============================================================================
// tb_tcdm_stall_injector : directed + random bench for three injector
// configurations (always-stall, never-stall, mid-probability with zero seed).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_tcdm_stall_injector;

   localparam int NCH = 5;  // a0, a1, b0, c0, c1
`ifdef TCDM_STALL_RESP_DELAY_EN
   localparam int RESP_LAT = 2;
`else
   localparam int RESP_LAT = 1;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic en = 1'b0;
   logic clr = 1'b0;

   logic        req   [NCH];
   logic        wen   [NCH];
   logic [3:0]  be    [NCH];
   logic [31:0] add   [NCH];
   logic [31:0] wdata [NCH];
   logic        mgnt  [NCH];

   logic        o_mreq [NCH];
   logic        o_mwen [NCH];
   logic [3:0]  o_mbe  [NCH];
   logic [31:0] o_madd [NCH];
   logic [31:0] o_mdata[NCH];
   logic        o_sgnt [NCH];
   logic        o_rvalid[NCH];
   logic [31:0] o_rdata[NCH];
   logic [31:0] o_cnt  [NCH];

   logic        mem_rv [NCH];
   logic [31:0] mem_rd [NCH];

   logic [1:0][31:0] cnt_a;
   logic [0:0][31:0] cnt_b;
   logic [1:0][31:0] cnt_c;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   hwpe_stream_intf_tcdm a_slv [2] ();
   hwpe_stream_intf_tcdm a_mst [2] ();
   hwpe_stream_intf_tcdm b_slv [1] ();
   hwpe_stream_intf_tcdm b_mst [1] ();
   hwpe_stream_intf_tcdm c_slv [2] ();
   hwpe_stream_intf_tcdm c_mst [2] ();

   tcdm_stall_injector #(.MP(2), .STALL_PROB(255), .MAX_STALL(4), .LFSR_SEED(8'h5A)) u_a (
      .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .clear_i(clr),
      .tcdm_slv(a_slv), .tcdm_mst(a_mst), .stall_cnt_o(cnt_a)
   );
   tcdm_stall_injector #(.MP(1), .STALL_PROB(0), .MAX_STALL(4), .LFSR_SEED(8'h5A)) u_b (
      .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .clear_i(clr),
      .tcdm_slv(b_slv), .tcdm_mst(b_mst), .stall_cnt_o(cnt_b)
   );
   tcdm_stall_injector #(.MP(2), .STALL_PROB(100), .MAX_STALL(2), .LFSR_SEED(8'h01)) u_c (
      .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .clear_i(clr),
      .tcdm_slv(c_slv), .tcdm_mst(c_mst), .stall_cnt_o(cnt_c)
   );

   for (genvar g = 0; g < 2; g++) begin : g_bind_a
      assign a_slv[g].req     = req[g];
      assign a_slv[g].add     = add[g];
      assign a_slv[g].wen     = wen[g];
      assign a_slv[g].be      = be[g];
      assign a_slv[g].data    = wdata[g];
      assign a_mst[g].gnt     = mgnt[g];
      assign a_mst[g].r_data  = mem_rd[g];
      assign a_mst[g].r_valid = mem_rv[g];
      assign o_mreq[g]   = a_mst[g].req;
      assign o_madd[g]   = a_mst[g].add;
      assign o_mwen[g]   = a_mst[g].wen;
      assign o_mbe[g]    = a_mst[g].be;
      assign o_mdata[g]  = a_mst[g].data;
      assign o_sgnt[g]   = a_slv[g].gnt;
      assign o_rvalid[g] = a_slv[g].r_valid;
      assign o_rdata[g]  = a_slv[g].r_data;
      assign o_cnt[g]    = cnt_a[g];
   end

   for (genvar g = 0; g < 1; g++) begin : g_bind_b
      assign b_slv[g].req     = req[2+g];
      assign b_slv[g].add     = add[2+g];
      assign b_slv[g].wen     = wen[2+g];
      assign b_slv[g].be      = be[2+g];
      assign b_slv[g].data    = wdata[2+g];
      assign b_mst[g].gnt     = mgnt[2+g];
      assign b_mst[g].r_data  = mem_rd[2+g];
      assign b_mst[g].r_valid = mem_rv[2+g];
      assign o_mreq[2+g]   = b_mst[g].req;
      assign o_madd[2+g]   = b_mst[g].add;
      assign o_mwen[2+g]   = b_mst[g].wen;
      assign o_mbe[2+g]    = b_mst[g].be;
      assign o_mdata[2+g]  = b_mst[g].data;
      assign o_sgnt[2+g]   = b_slv[g].gnt;
      assign o_rvalid[2+g] = b_slv[g].r_valid;
      assign o_rdata[2+g]  = b_slv[g].r_data;
      assign o_cnt[2+g]    = cnt_b[g];
   end

   for (genvar g = 0; g < 2; g++) begin : g_bind_c
      assign c_slv[g].req     = req[3+g];
      assign c_slv[g].add     = add[3+g];
      assign c_slv[g].wen     = wen[3+g];
      assign c_slv[g].be      = be[3+g];
      assign c_slv[g].data    = wdata[3+g];
      assign c_mst[g].gnt     = mgnt[3+g];
      assign c_mst[g].r_data  = mem_rd[3+g];
      assign c_mst[g].r_valid = mem_rv[3+g];
      assign o_mreq[3+g]   = c_mst[g].req;
      assign o_madd[3+g]   = c_mst[g].add;
      assign o_mwen[3+g]   = c_mst[g].wen;
      assign o_mbe[3+g]    = c_mst[g].be;
      assign o_mdata[3+g]  = c_mst[g].data;
      assign o_sgnt[3+g]   = c_slv[g].gnt;
      assign o_rvalid[3+g] = c_slv[g].r_valid;
      assign o_rdata[3+g]  = c_slv[g].r_data;
      assign o_cnt[3+g]    = cnt_c[g];
   end

   // Memory model: one-cycle read response whose data is the inverted address
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < NCH; c++) begin
            mem_rv[c] <= 1'b0;
            mem_rd[c] <= 32'd0;
         end
      end else begin
         for (int c = 0; c < NCH; c++) begin
            mem_rv[c] <= o_mreq[c] & mgnt[c];
            mem_rd[c] <= ~o_madd[c];
         end
      end
   end

   // ---------------- reference model ----------------
   int         p_thr  [NCH] = '{255, 255, 0, 100, 100};
   int         p_max  [NCH] = '{4, 4, 4, 2, 2};
   logic [7:0] p_seed [NCH];

   logic [7:0]  m_lfsr [NCH];
   logic [3:0]  m_run  [NCH];
   logic [31:0] m_cnt  [NCH];
   logic        rv1 [NCH], rv2 [NCH];
   logic [31:0] ra1 [NCH], ra2 [NCH];

   function automatic logic [7:0] seed_of(input logic [7:0] base, input int idx);
      logic [7:0] s;
      s = base ^ 8'(idx);
      return (s == 8'h00) ? 8'hA5 : s;
   endfunction

   // Multiply the state by x^-1 modulo x^8+x^6+x^5+x^4+1
   function automatic logic [7:0] lfsr_step(input logic [7:0] v);
      logic [8:0] t;
      t = {1'b0, v};
      if (t[0]) t = t ^ 9'h171;
      return t[8:1];
   endfunction

   function automatic logic m_stall(input int c);
      return en && req[c] && (int'(m_lfsr[c]) < p_thr[c]) && (int'(m_run[c]) < p_max[c]);
   endfunction

   function automatic logic m_gnt(input int c);
      return rst_n && mgnt[c] && !m_stall(c);
   endfunction

   function automatic logic m_mreq(input int c);
      return rst_n && req[c] && !m_stall(c);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < NCH; c++) begin
            m_lfsr[c] <= p_seed[c];
            m_run[c]  <= 4'd0;
            m_cnt[c]  <= 32'd0;
            rv1[c] <= 1'b0; rv2[c] <= 1'b0;
            ra1[c] <= 32'd0; ra2[c] <= 32'd0;
         end
      end else begin
         for (int c = 0; c < NCH; c++) begin
            if (en) m_lfsr[c] <= lfsr_step(m_lfsr[c]);
            if (m_stall(c)) m_run[c] <= m_run[c] + 4'd1;
            else if (!req[c] || m_gnt(c)) m_run[c] <= 4'd0;
            if (clr) m_cnt[c] <= 32'd0;
            else if (m_stall(c) && m_cnt[c] != 32'hFFFF_FFFF) m_cnt[c] <= m_cnt[c] + 32'd1;
            rv1[c] <= req[c] && m_gnt(c);
            ra1[c] <= add[c];
            rv2[c] <= rv1[c];
            ra2[c] <= ra1[c];
         end
      end
   end

   // ---------------- checking ----------------
   task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s ch%0d: observed=%h expected=%h", tag, c, obs, exp);
      end
   endtask

   task automatic check_all();
      logic        erv;
      logic [31:0] era;
      for (int c = 0; c < NCH; c++) begin
         erv = (RESP_LAT == 2) ? rv2[c] : rv1[c];
         era = (RESP_LAT == 2) ? ra2[c] : ra1[c];
         chk("mst_req", c, 32'(o_mreq[c]), 32'(m_mreq(c)));
         chk("slv_gnt", c, 32'(o_sgnt[c]), 32'(m_gnt(c)));
         chk("stall_cnt", c, o_cnt[c], m_cnt[c]);
         chk("pass_add", c, o_madd[c], add[c]);
         chk("pass_ctl", c, {27'd0, o_mwen[c], o_mbe[c]}, {27'd0, wen[c], be[c]});
         chk("pass_data", c, o_mdata[c], wdata[c]);
         chk("r_valid", c, 32'(o_rvalid[c]), 32'(erv));
         if (erv) chk("r_data", c, o_rdata[c], ~era);
      end
   endtask

   task automatic sample();
      @(negedge clk);
      check_all();
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   logic held [NCH];

   initial begin
      p_seed = '{seed_of(8'h5A, 0), seed_of(8'h5A, 1), seed_of(8'h5A, 0),
                 seed_of(8'h01, 0), seed_of(8'h01, 1)};
      // Requests and grants asserted during reset must not pass through
      for (int c = 0; c < NCH; c++) begin
         req[c] = 1'b1; wen[c] = 1'b1; be[c] = 4'hF;
         add[c] = 32'h100 + 32'(c * 4); wdata[c] = 32'd0; mgnt[c] = 1'b1;
      end
      repeat (2) begin
         sample();
         chk("rst_gnt", 0, 32'(o_sgnt[0]), 32'd0);
         chk("rst_mreq", 3, 32'(o_mreq[3]), 32'd0);
         adv();
      end
      rst_n = 1'b1;

      // Transparent single read at 0x10
      for (int c = 0; c < NCH; c++) begin
         req[c] = 1'b1; add[c] = 32'h10; wen[c] = 1'b1;
      end
      sample();
      chk("t_mreq", 0, 32'(o_mreq[0]), 32'd1);
      chk("t_gnt", 0, 32'(o_sgnt[0]), 32'd1);
      adv();
      for (int c = 0; c < NCH; c++) req[c] = 1'b0;
      repeat (2) begin sample(); adv(); end
      chk("t_cnt", 0, o_cnt[0], 32'd0);

      // Always-stall port 0 of u_a: four stalls then a forced grant
      en = 1'b1;
      req[0] = 1'b1; add[0] = 32'h20;
      for (int k = 1; k <= 5; k++) begin
         sample();
         chk("hold_gnt", 0, 32'(o_sgnt[0]), 32'(k == 5));
         chk("hold_mreq", 0, 32'(o_mreq[0]), 32'(k == 5));
         adv();
      end
      req[0] = 1'b0;
      sample();
      chk("hold_cnt", 0, o_cnt[0], 32'd4);
      chk("idle_port_cnt", 1, o_cnt[1], 32'd0);
      adv();

      // Clear while stalling at a count of 7, then resume from 1
      req[0] = 1'b1; add[0] = 32'h24;
      for (int k = 1; k <= 3; k++) begin
         sample();
         chk("pre_clr_gnt", 0, 32'(o_sgnt[0]), 32'd0);
         adv();
      end
      clr = 1'b1;
      sample();
      chk("pre_clr_cnt", 0, o_cnt[0], 32'd7);
      adv();
      clr = 1'b0;
      sample();
      chk("post_clr_cnt", 0, o_cnt[0], 32'd0);
      chk("post_clr_gnt", 0, 32'(o_sgnt[0]), 32'd1);
      adv();
      sample();
      adv();
      req[0] = 1'b0;
      sample();
      chk("resume_cnt", 0, o_cnt[0], 32'd1);
      adv();

      // Never-stall config: 100 back-to-back writes
      for (int n = 0; n < 100; n++) begin
         req[2] = 1'b1; wen[2] = 1'b0; be[2] = 4'($urandom_range(15));
         add[2] = $urandom & 32'hFFFF_FFFC; wdata[2] = $urandom;
         sample();
         chk("wr_gnt", 2, 32'(o_sgnt[2]), 32'd1);
         adv();
      end
      req[2] = 1'b0;
      sample();
      chk("wr_cnt", 2, o_cnt[2], 32'd0);
      adv();

      // Randomized traffic, with a reset pulse landing mid-stream
      for (int n = 0; n < 400; n++) begin
         sample();
         for (int c = 0; c < NCH; c++) held[c] = req[c] && !o_sgnt[c];
         adv();
         if (n == 200) rst_n = 1'b0;
         if (n == 202) rst_n = 1'b1;
         if ($urandom_range(15) == 0) en = ~en;
         clr = ($urandom_range(31) == 0);
         for (int c = 0; c < NCH; c++) begin
            if (!held[c]) begin
               req[c]   = ($urandom_range(2) != 0);
               wen[c]   = 1'($urandom_range(1));
               be[c]    = 4'($urandom_range(15));
               add[c]   = $urandom & 32'hFFFF_FFFC;
               wdata[c] = $urandom;
            end
            mgnt[c] = ($urandom_range(3) != 0);
         end
      end
      sample();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
